// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal segments,
// one per register stage, with an elastic valid/ready handshake at both ends.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             C_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] beff;

  // The whole pipe moves as one: a stalled output freezes every stage, bubbles included.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign beff     = sub ? ~B : B;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SEG;
      localparam int HI = LO + SEG - 1;

      logic [WIDTH-1:LO] a_src;
      logic [WIDTH-1:LO] b_src;
      logic              valid_src;
      logic              carry_src;
      logic [HI:0]       sum_next;
      logic [SEG:0]      seg_sum;

      logic              valid_q;
      logic              carry_q;
      logic [HI:0]       sum_q;

      if (k == 0) begin : g_src
        assign a_src     = A;
        assign b_src     = beff;
        assign valid_src = in_valid;
        assign carry_src = C_in;
        assign sum_next  = seg_sum[SEG-1:0];
      end else begin : g_src
        assign a_src     = g_stage[k-1].g_skew.a_q;
        assign b_src     = g_stage[k-1].g_skew.b_q;
        assign valid_src = g_stage[k-1].valid_q;
        assign carry_src = g_stage[k-1].carry_q;
        assign sum_next  = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
      end

      assign seg_sum = {1'b0, a_src[HI:LO]} + {1'b0, b_src[HI:LO]} + {{SEG{1'b0}}, carry_src};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          sum_q   <= '0;
        end else if (advance) begin
          valid_q <= valid_src;
          carry_q <= seg_sum[SEG];
          sum_q   <= sum_next;
        end
      end

      // Operand slices not yet added travel alongside the partial sum.
      if (k < STAGES - 1) begin : g_skew
        logic [WIDTH-1:HI+1] a_q;
        logic [WIDTH-1:HI+1] b_q;

        always_ff @(posedge clk) begin
          if (advance) begin
            a_q <= a_src[WIDTH-1:HI+1];
            b_q <= b_src[WIDTH-1:HI+1];
          end
        end
      end

      if (k == STAGES - 1) begin : g_flags
        logic ovf_q;
        logic zero_q;

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
          end else if (advance) begin
            ovf_q  <= (a_src[HI] == b_src[HI]) & (seg_sum[SEG-1] != a_src[HI]);
            zero_q <= (sum_next == '0);
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign C_out     = g_stage[STAGES-1].carry_q;
  assign overflow  = g_stage[STAGES-1].g_flags.ovf_q;
  assign zero      = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed plus randomized bench for pipe_addsub; a scoreboard queue holds the
// expected results in acceptance order and is drained as outputs are consumed.
module tb_pipe_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t sb[$];

  pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .C_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .C_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t           m;
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   r;
    be      = sv ? ~bv : bv;
    r       = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, cv};
    m.sum   = r[WIDTH-1:0];
    m.c_out = r[WIDTH];
    m.ovf   = (av[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != av[WIDTH-1]);
    m.zero  = (r[WIDTH-1:0] == '0);
    return m;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare the head entry every cycle a result is shown, pop on handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_output: observed sum=%h expected no result", sum);
        end
        if (sb.size() != 0) begin
          e = sb[0];
          check_word("sb_sum", sum, e.sum);
          check_bit("sb_c_out", c_out, e.c_out);
          check_bit("sb_overflow", overflow, e.ovf);
          check_bit("sb_zero", zero, e.zero);
          if (out_ready) begin
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, c_in, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                input logic c_i, input logic s_i);
    a        = a_i;
    b        = b_i;
    c_in     = c_i;
    sub      = s_i;
    in_valid = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    check_count({tag, "_drained"}, sb.size(), 0);
  endtask

  // One isolated transaction: exact latency and the result against fixed values.
  task automatic run_one(input string tag, input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                         input logic c_i, input logic s_i, input logic [WIDTH-1:0] exp_sum,
                         input logic exp_c, input logic exp_ov, input logic exp_z);
    out_ready = 1'b1;
    apply_stimulus(a_i, b_i, c_i, s_i);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      check_bit({tag, "_not_yet_valid"}, out_valid, 1'b0);
      tick();
    end
    check_bit({tag, "_out_valid"}, out_valid, 1'b1);
    check_word({tag, "_sum"}, sum, exp_sum);
    check_bit({tag, "_c_out"}, c_out, exp_c);
    check_bit({tag, "_overflow"}, overflow, exp_ov);
    check_bit({tag, "_zero"}, zero, exp_z);
    tick();
  endtask

  initial begin
    int n0;
    int sent;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    tick();
    tick();
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_bit("idle_out_valid", out_valid, 1'b0);
      check_bit("idle_in_ready", in_ready, 1'b1);
      check_word("idle_sum", sum, 32'h0000_0000);
      tick();
    end

    $display("[TB] directed arithmetic cases");
    run_one("wrap_to_zero", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("pos_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);

    $display("[TB] back-to-back with output stall on cycles 5-7");
    n0   = n_out;
    sent = 0;
    for (int c = 1; c <= 20 && sent < 8; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      apply_stimulus(sent + 1, sent + 1, 1'b0, 1'b0);
      #1;
      check_bit("stall_in_ready", in_ready, (c < 5 || c > 7));
      if (in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_count("stall_accepted", sent, 8);
    drain("stall");
    check_count("stall_results", n_out - n0, 8);

    $display("[TB] reset with transactions in flight");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(100 + i, 32'h0000_0001, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    apply_stimulus(32'h0000_DEAD, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_bit("flush_out_valid", out_valid, 1'b0);
      tick();
    end
    run_one("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("[TB] random traffic with random backpressure");
    n0   = n_out;
    sent = 0;
    for (int c = 0; c < 400 && sent < 40; c++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0)
        apply_stimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("random");
    check_count("random_results", n_out - n0, sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
